// File: rtl/array_fn_scheduler.sv
// rtl/array_fn_scheduler.sv - round-robin scheduler sharing one array function unit among requesters
// Optional macro ARRAY_FN_SCHED_TIMEOUT_EN enables a WAIT-state timeout abort.
module array_fn_scheduler #(
  parameter int NUM     = 8,
  parameter int DSIZE   = 8,
  parameter int REQ_NUM = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                           clock,
  input  logic                           rst_n,
  input  logic [REQ_NUM-1:0]             req_valid,
  output logic [REQ_NUM-1:0]             req_ready,
  input  logic [REQ_NUM*DSIZE-1:0]       req_ain,
  input  logic [REQ_NUM*NUM*DSIZE-1:0]   req_array,
  output logic [REQ_NUM-1:0]             rsp_valid,
  input  logic [REQ_NUM-1:0]             rsp_ready,
  output logic [DSIZE-1:0]               rsp_bout,
  output logic [NUM*DSIZE-1:0]           rsp_array,
  output logic                           rsp_err,
  output logic                           fn_start,
  output logic [DSIZE-1:0]               fn_ain,
  output logic [NUM*DSIZE-1:0]           fn_in_array,
  input  logic                           fn_done,
  input  logic [DSIZE-1:0]               fn_bout,
  input  logic [NUM*DSIZE-1:0]           fn_out_array
);

  localparam int PTR_W = $clog2(REQ_NUM);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [DSIZE-1:0]     fn_ain_q, fn_ain_d;
  logic [NUM*DSIZE-1:0] fn_in_array_q, fn_in_array_d;
  logic [DSIZE-1:0]     rsp_bout_q, rsp_bout_d;
  logic [NUM*DSIZE-1:0] rsp_array_q, rsp_array_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [PTR_W-1:0]     grant;
  logic                 timeout_hit;

  // First pending requester at or after rr_ptr, wrapping at REQ_NUM (not 2**PTR_W).
  always_comb begin
    int   idx;
    logic found;
    grant = rr_ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < REQ_NUM; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= REQ_NUM) idx = idx - REQ_NUM;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = idx[PTR_W-1:0];
      end
    end
  end

`ifdef ARRAY_FN_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                wait_cnt_q <= '0;
    else if (state_q != WAIT)  wait_cnt_q <= '0;
    else                       wait_cnt_q <= wait_cnt_q + 1'b1;
  end

  assign timeout_hit = (state_q == WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT - 1));
`else
  wire unused_timeout = (TIMEOUT > 0);
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    fn_ain_d      = fn_ain_q;
    fn_in_array_d = fn_in_array_q;
    rsp_bout_d    = rsp_bout_q;
    rsp_array_d   = rsp_array_q;
    rsp_err_d     = rsp_err_q;
    case (state_q)
      IDLE: if (|req_valid) begin
        fn_ain_d      = req_ain[grant*DSIZE +: DSIZE];
        fn_in_array_d = req_array[grant*(NUM*DSIZE) +: NUM*DSIZE];
        owner_d       = grant;
        state_d       = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // A done strobe in the timeout cycle still counts as normal completion.
        if (fn_done) begin
          rsp_bout_d  = fn_bout;
          rsp_array_d = fn_out_array;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (timeout_hit) begin
          rsp_bout_d  = '0;
          rsp_array_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end
      end
      default: if (rsp_ready[owner_q]) begin
        rr_ptr_d = (owner_q == PTR_W'(REQ_NUM - 1)) ? '0 : owner_q + 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      fn_ain_q      <= '0;
      fn_in_array_q <= '0;
      rsp_bout_q    <= '0;
      rsp_array_q   <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      fn_ain_q      <= fn_ain_d;
      fn_in_array_q <= fn_in_array_d;
      rsp_bout_q    <= rsp_bout_d;
      rsp_array_q   <= rsp_array_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign req_ready   = (rst_n && state_q == IDLE && |req_valid) ? (REQ_NUM'(1) << grant) : '0;
  assign rsp_valid   = (state_q == RESP) ? (REQ_NUM'(1) << owner_q) : '0;
  assign fn_start    = (state_q == ISSUE);
  assign fn_ain      = fn_ain_q;
  assign fn_in_array = fn_in_array_q;
  assign rsp_bout    = rsp_bout_q;
  assign rsp_array   = rsp_array_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_array_fn_scheduler.sv
// tb/tb_array_fn_scheduler.sv - directed-vector bench for array_fn_scheduler
module tb_array_fn_scheduler;
  localparam int NUM = 8, DSIZE = 8, REQ_NUM = 4, TIMEOUT = 16;

  logic                         clock = 1'b0;
  logic                         rst_n;
  logic [REQ_NUM-1:0]           req_valid, req_ready, rsp_valid, rsp_ready;
  logic [REQ_NUM*DSIZE-1:0]     req_ain;
  logic [REQ_NUM*NUM*DSIZE-1:0] req_array;
  logic [DSIZE-1:0]             rsp_bout, fn_ain, fn_bout;
  logic [NUM*DSIZE-1:0]         rsp_array, fn_in_array, fn_out_array;
  logic                         rsp_err, fn_start, fn_done;

  int n_vec = 0;
  int n_err = 0;

  array_fn_scheduler #(.NUM(NUM), .DSIZE(DSIZE), .REQ_NUM(REQ_NUM), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_ain(req_ain), .req_array(req_array),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bout(rsp_bout), .rsp_array(rsp_array),
    .rsp_err(rsp_err), .fn_start(fn_start), .fn_ain(fn_ain), .fn_in_array(fn_in_array),
    .fn_done(fn_done), .fn_bout(fn_bout), .fn_out_array(fn_out_array)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  function automatic logic [REQ_NUM-1:0] oh(input int i);
    return REQ_NUM'(1) << i;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; fn_done = 1'b0; fn_bout = '0; fn_out_array = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      req_ain[i*DSIZE +: DSIZE] = 8'h30 + 8'(i);
      req_array[i*NUM*DSIZE +: NUM*DSIZE] = {8{8'h40 + 8'(i)}};
    end

    // Reset state
    req_valid = 4'b1111;
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'h0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_fn_start", 64'(fn_start), 64'h0);
    chk("reset_fn_in_array", fn_in_array, 64'h0);
    req_valid = '0;
    do_reset();

    // Single request from requester 2
    req_ain[2*DSIZE +: DSIZE] = 8'h5A;
    req_array[2*NUM*DSIZE +: NUM*DSIZE] = 64'h0102030405060708;
    req_valid = 4'b0100;
    #1 chk("single_req_ready", 64'(req_ready), 64'h4);
    step();
    req_valid = '0;
    chk("single_fn_start", 64'(fn_start), 64'h1);
    chk("single_fn_ain", 64'(fn_ain), 64'h5A);
    chk("single_fn_in_array", fn_in_array, 64'h0102030405060708);
    step();
    chk("single_start_once", 64'(fn_start), 64'h0);
    step();
    step();
    chk("single_no_rsp_yet", 64'(rsp_valid), 64'h0);
    fn_done = 1'b1; fn_bout = 8'hA5; fn_out_array = 64'hF0E1D2C3B4A59687;
    step();
    fn_done = 1'b0;
    chk("single_rsp_valid", 64'(rsp_valid), 64'h4);
    chk("single_rsp_bout", 64'(rsp_bout), 64'hA5);
    chk("single_rsp_array", rsp_array, 64'hF0E1D2C3B4A59687);
    chk("single_rsp_err", 64'(rsp_err), 64'h0);
    chk("single_fn_ain_held", 64'(fn_ain), 64'h5A);
    rsp_ready = 4'b0100;
    step();
    rsp_ready = '0;
    chk("single_rsp_done", 64'(rsp_valid), 64'h0);
    req_ain[2*DSIZE +: DSIZE] = 8'h32;

    // Round-robin with all requesters pending, from a fresh pointer
    do_reset();
    req_valid = 4'b1111; rsp_ready = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_grant", 64'(req_ready), 64'(oh(k % 4)));
      step();
      chk("rr_fn_ain", 64'(fn_ain), 64'(8'h30 + 8'(k % 4)));
      step();
      fn_done = 1'b1; fn_bout = 8'h10 + 8'(k);
      step();
      fn_done = 1'b0;
      chk("rr_rsp_valid", 64'(rsp_valid), 64'(oh(k % 4)));
      chk("rr_rsp_bout", 64'(rsp_bout), 64'(8'h10 + 8'(k)));
      step();
    end
    req_valid = '0; rsp_ready = '0;

    // Response backpressure; rr_ptr is now 1
    req_valid = 4'b0010;
    #1 chk("bp_grant", 64'(req_ready), 64'h2);
    step();
    req_valid = 4'b1111;
    step();
    fn_done = 1'b1; fn_bout = 8'h66; fn_out_array = 64'h1122334455667788;
    step();
    fn_done = 1'b0;
    rsp_ready = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_rsp_valid", 64'(rsp_valid), 64'h2);
      chk("bp_rsp_array", rsp_array, 64'h1122334455667788);
      chk("bp_req_ready", 64'(req_ready), 64'h0);
      chk("bp_fn_start", 64'(fn_start), 64'h0);
      step();
    end
    rsp_ready = 4'b0010;
    step();
    rsp_ready = '0;
    chk("bp_released", 64'(rsp_valid), 64'h0);
    #1 chk("bp_next_grant", 64'(req_ready), 64'h4);
    req_valid = '0;

    // Spurious done in IDLE and ISSUE
    fn_done = 1'b1; fn_bout = 8'hEE;
    step();
    fn_done = 1'b0;
    chk("spur_idle_rsp", 64'(rsp_valid), 64'h0);
    chk("spur_idle_start", 64'(fn_start), 64'h0);
    req_valid = 4'b1000;
    #1 chk("spur_grant", 64'(req_ready), 64'h8);
    step();
    req_valid = '0;
    chk("spur_fn_start", 64'(fn_start), 64'h1);
    fn_done = 1'b1;
    step();
    fn_done = 1'b0;
    chk("spur_issue_rsp", 64'(rsp_valid), 64'h0);
    step();
    chk("spur_still_wait", 64'(rsp_valid), 64'h0);
    fn_done = 1'b1; fn_bout = 8'h77;
    step();
    fn_done = 1'b0;
    chk("spur_real_rsp", 64'(rsp_valid), 64'h8);
    chk("spur_real_bout", 64'(rsp_bout), 64'h77);
    rsp_ready = 4'b1000;
    step();
    rsp_ready = '0;

    // Unit never completes; rr_ptr is now 0
    req_valid = 4'b0001;
    #1 chk("stuck_grant", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    step();
`ifdef ARRAY_FN_SCHED_TIMEOUT_EN
    for (int i = 1; i < TIMEOUT; i++) step();
    chk("to_not_early", 64'(rsp_valid), 64'h0);
    step();
    chk("to_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("to_rsp_err", 64'(rsp_err), 64'h1);
    chk("to_rsp_bout", 64'(rsp_bout), 64'h0);
    chk("to_rsp_array", rsp_array, 64'h0);
`else
    repeat (1000) step();
    chk("stuck_no_rsp", 64'(rsp_valid), 64'h0);
    chk("stuck_err", 64'(rsp_err), 64'h0);
    req_valid = 4'b1110;
    #1 chk("stuck_no_ready", 64'(req_ready), 64'h0);
`endif

    // Reset mid-transaction, then a stale done
    req_valid = 4'b1011;
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_fn_start", 64'(fn_start), 64'h0);
    chk("rst_fn_ain", 64'(fn_ain), 64'h0);
    chk("rst_fn_in_array", fn_in_array, 64'h0);
    chk("rst_rsp_bout", 64'(rsp_bout), 64'h0);
    chk("rst_rsp_array", rsp_array, 64'h0);
    chk("rst_rsp_err", 64'(rsp_err), 64'h0);
    step();
    req_valid = '0;
    rst_n = 1'b1;
    fn_done = 1'b1; fn_bout = 8'hFF;
    step();
    fn_done = 1'b0;
    chk("stale_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("stale_fn_start", 64'(fn_start), 64'h0);
    req_valid = 4'b1011;
    #1 chk("rst_next_grant", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    chk("rst_next_fn_ain", 64'(fn_ain), 64'h30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/array_fn_scheduler.md
Name: array_fn_scheduler

Overview:
- Shares one `test_struct_function`-style array datapath (scalar `ain` plus NUM-element `in_array` in; scalar `bout` plus `out_array` out) between REQ_NUM requesters.
- Round-robin arbitration, one transaction at a time.
- Latches the winner's operands, starts the shared unit, waits for its done strobe, and returns the result to the owning requester over a valid/ready response channel.

Parameters:
- NUM, 8, elements per array.
- DSIZE, 8, bits per element and per scalar.
- REQ_NUM, 4, number of requesters (2..16).
- TIMEOUT, 64, cycles allowed in WAIT before abort (used only with the optional feature).

Ports:
- clock  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  REQ_NUM  per-requester request valid.
- req_ready  out  REQ_NUM  per-requester accept; one-hot or zero.
- req_ain  in  REQ_NUM*DSIZE  scalar operand; requester i at slice [i*DSIZE +: DSIZE].
- req_array  in  REQ_NUM*NUM*DSIZE  array operand; requester i at slice [i*NUM*DSIZE +: NUM*DSIZE].
- rsp_valid  out  REQ_NUM  per-requester response valid; one-hot or zero.
- rsp_ready  in  REQ_NUM  per-requester response accept.
- rsp_bout  out  DSIZE  result scalar, shared by all requesters.
- rsp_array  out  NUM*DSIZE  result array, shared by all requesters.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- fn_start  out  1  one-cycle start pulse to the shared unit.
- fn_ain  out  DSIZE  operand to the unit.
- fn_in_array  out  NUM*DSIZE  operand to the unit.
- fn_done  in  1  one-cycle completion strobe from the unit.
- fn_bout  in  DSIZE  unit result, valid with fn_done.
- fn_out_array  in  NUM*DSIZE  unit result, valid with fn_done.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `rst_n` is asynchronous and active-low. On assertion, at any time including mid-transaction:
  - state=IDLE, rr_ptr=0, owner=0;
  - fn_start=0, fn_ain=0, fn_in_array=0;
  - rsp_valid=0, rsp_bout=0, rsp_array=0, rsp_err=0.
  - req_ready evaluates to 0 during reset.
  - The in-flight transaction is dropped; a late fn_done after reset is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = first set bit of req_valid scanning rr_ptr, rr_ptr+1, ... mod REQ_NUM.
  - req_ready[grant] = 1 combinationally when any req_valid is set; all other bits 0.
  - On handshake (cycle T): latch req_ain/req_array slice into fn_ain/fn_in_array, owner=grant, go to ISSUE.
  - Requesters hold valid and operands stable until ready; deasserting valid before ready is legal and no grant occurs.
- ISSUE (T+1): fn_start=1 for exactly one cycle, then go to WAIT. fn_ain/fn_in_array stay stable from T+1 until leaving WAIT.
- WAIT:
  - fn_done is sampled only in WAIT. A fn_done in IDLE, ISSUE or RESP is ignored.
  - On fn_done: capture fn_bout/fn_out_array into rsp_bout/rsp_array, rsp_err=0, rsp_valid[owner]=1, go to RESP.
  - Minimum latency: fn_done at T+2 gives rsp_valid at T+3.
- RESP:
  - rsp_valid[owner] held with stable data until rsp_ready[owner]=1.
  - rsp_ready on other bits is ignored.
  - On handshake: rsp_valid=0, rr_ptr=(owner+1) mod REQ_NUM, go to IDLE. The next grant is possible in the following cycle.
- Fairness: the most recent owner is lowest priority next round. Any requester waits at most REQ_NUM-1 transactions.
- Width rules:
  - Data passes through unchanged; no arithmetic on data.
  - rr_ptr and owner are $clog2(REQ_NUM) bits; wrap at REQ_NUM-1 → 0 also for non-power-of-2 REQ_NUM.
- No request queuing: exactly one transaction outstanding. req_ready=0 in ISSUE, WAIT and RESP.

Optional Feature:
- ARRAY_FN_SCHED_TIMEOUT_EN defined:
  - A WAIT cycle counter starts at 0 on WAIT entry.
  - If it reaches TIMEOUT-1 without fn_done: go to RESP with rsp_err=1, rsp_bout=0, rsp_array=0.
  - fn_done in that same cycle wins (normal completion, rsp_err=0).
- Macro undefined: no counter; WAIT lasts indefinitely; rsp_err tied 0.

Test Plan:
- Single request: REQ_NUM=4, req_valid=4'b0100, ain=8'h5A; unit returns done 3 cycles after fn_start with bout=8'hA5 → req_ready=4'b0100 at T, fn_start at T+1, fn_ain=8'h5A, rsp_valid=4'b0100 at T+5, rsp_bout=8'hA5.
- Round-robin: req_valid=4'b1111 held, rsp_ready=all 1 → grant order 0,1,2,3,0; no requester granted twice before every other pending one.
- Response backpressure: rsp_ready[owner]=0 for 10 cycles → rsp_valid and rsp_array stable all 10 cycles, req_ready=0, no new fn_start.
- Spurious done: fn_done pulsed in IDLE and in ISSUE → no state change, no rsp_valid.
- Reset mid-WAIT: rst_n low while in WAIT, then fn_done after release → all outputs 0, next grant goes to requester 0 if valid, stale done ignored.
- With ARRAY_FN_SCHED_TIMEOUT_EN, TIMEOUT=16, fn_done never arrives → rsp_valid[owner]=1 with rsp_err=1 and rsp_bout=0 at 16 cycles after WAIT entry. Without the macro → still in WAIT after 1000 cycles.
